adc_multich_avg_decimator: RTL and testbench

//  N-channel signed ADC sample averager, runtime-selectable window 2^len_log2.
//  Two modes: sliding moving average (one output per input), or block average decimated by window length.

---
 rtl/adc_multich_avg_decimator.sv | 148 ++++++++++++++
 tb/tb_adc_multich_avg_decimator.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_multich_avg_decimator.sv
// N-channel signed sample averager: sliding moving average or block average/decimate.
// Optional ADC_AVG_ROUND_EN: round half up before the shift and saturate to W bits.
module adc_multich_avg_decimator #(
  parameter int N_CH     = 4,
  parameter int W        = 16,
  parameter int LOG2_MAX = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [$clog2(LOG2_MAX+1)-1:0]   len_log2,
  input  logic                            mode,
  input  logic                            in_valid,
  input  logic [N_CH*W-1:0]               in_data,
  output logic                            out_valid,
  output logic [N_CH*W-1:0]               out_data,
  output logic                            fill_done
);

  localparam int LW    = $clog2(LOG2_MAX+1);
  localparam int AW    = W + LOG2_MAX;
  localparam int PW    = LOG2_MAX;
  localparam int CW    = LOG2_MAX + 1;
  localparam int DEPTH = 1 << LOG2_MAX;

  logic [LW-1:0]     lat_len;
  logic              lat_mode;
  logic [LW-1:0]     lg;
  logic [CW-1:0]     len_l;
  logic [CW-1:0]     fill_cnt;
  logic [CW-1:0]     fill_n;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     blk_cnt;
  logic              flush;
  logic              adv;
  logic              full;
  logic              blk_last;
  logic              fire;
  logic [N_CH*W-1:0] avg_all;

  // Outside a flush the live config equals the latch, so the latch drives all math.
  assign lg       = (lat_len > LW'(LOG2_MAX)) ? LW'(LOG2_MAX) : lat_len;
  assign len_l    = CW'(1) << lg;
  assign flush    = !enable || (len_log2 != lat_len) || (mode != lat_mode);
  assign adv      = in_valid && !flush;
  assign full     = (fill_cnt == len_l);
  assign fill_n   = full ? fill_cnt : fill_cnt + CW'(1);
  assign rd_ptr   = wr_ptr - len_l[PW-1:0];
  assign blk_last = ({1'b0, blk_cnt} == len_l - CW'(1));
  assign fire     = adv && (lat_mode ? blk_last : (fill_n == len_l));
  assign fill_done = !lat_mode && full;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic signed [W-1:0]  hist [DEPTH];
    logic signed [W-1:0]  xn;
    logic signed [W-1:0]  xo;
    logic signed [AW-1:0] xe;
    logic signed [AW-1:0] oe;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_n;
    logic [W-1:0]         avg;

    assign xn = in_data[c*W +: W];
    assign xo = full ? hist[rd_ptr] : '0;
    assign xe = {{LOG2_MAX{xn[W-1]}}, xn};
    assign oe = {{LOG2_MAX{xo[W-1]}}, xo};

    always_comb begin
      acc_n = acc;
      if (lat_mode)
        acc_n = (blk_cnt == '0) ? xe : acc + xe;
      else
        acc_n = acc + xe - oe;
    end

`ifdef ADC_AVG_ROUND_EN
    localparam logic signed [AW:0] SMAX = (AW+1)'((1 << (W-1)) - 1);
    localparam logic signed [AW:0] SMIN = -SMAX - 1;
    logic signed [AW:0] ext;
    logic signed [AW:0] half;
    logic signed [AW:0] rs;
    logic signed [AW:0] q;

    assign ext  = {acc_n[AW-1], acc_n};
    assign half = ((AW+1)'(1) << lg) >> 1;
    assign rs   = ext + half;
    assign q    = rs >>> lg;

    always_comb begin
      avg = q[W-1:0];
      if (q > SMAX)
        avg = SMAX[W-1:0];
      else if (q < SMIN)
        avg = SMIN[W-1:0];
    end
`else
    assign avg = W'(acc_n >>> lg);
`endif

    assign avg_all[c*W +: W] = avg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        acc <= '0;
      else if (flush)
        acc <= '0;
      else if (adv)
        acc <= acc_n;
    end

    always_ff @(posedge clk) begin
      if (adv && !lat_mode)
        hist[wr_ptr] <= xn;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_len   <= '0;
      lat_mode  <= 1'b0;
      fill_cnt  <= '0;
      wr_ptr    <= '0;
      blk_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      lat_len   <= len_log2;
      lat_mode  <= mode;
      out_valid <= fire;
      if (flush) begin
        fill_cnt <= '0;
        wr_ptr   <= '0;
        blk_cnt  <= '0;
      end else if (adv) begin
        if (lat_mode) begin
          blk_cnt <= blk_last ? '0 : blk_cnt + PW'(1);
        end else begin
          wr_ptr   <= wr_ptr + PW'(1);
          fill_cnt <= fill_n;
        end
      end
      if (fire)
        out_data <= avg_all;
    end
  end

endmodule

// File: tb/tb_adc_multich_avg_decimator.sv
// Directed + random bench for adc_multich_avg_decimator.
// Reference model keeps raw samples since the last flush and averages them.
module tb_adc_multich_avg_decimator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [2:0]  len_log2;
  logic        mode;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_valid;
  logic [63:0] out_data;
  logic        fill_done;

  adc_multich_avg_decimator #(
    .N_CH(4), .W(16), .LOG2_MAX(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .len_log2(len_log2),
    .mode(mode),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        fd;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] samp[$];
  int          mlen;
  bit          mmode;
  logic [63:0] m_out;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mavg(input int lg);
    logic [63:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      longint s;
      logic signed [15:0] t;
      s = 0;
      for (int k = 0; k < samp.size(); k++) begin
        t = samp[k][c*16 +: 16];
        s += longint'(t);
      end
`ifdef ADC_AVG_ROUND_EN
      if (lg > 0) s += longint'(1) << (lg - 1);
      s = s >>> lg;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`else
      s = s >>> lg;
`endif
      r[c*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    mlen  = 0;
    mmode = 1'b0;
    m_out = '0;
    samp.delete();
  endtask

  task automatic model(input bit e, input int l, input bit m, input bit v,
                       input logic [63:0] d, output exp_t x);
    bit fl;
    int lg;
    int L;
    fl    = !e || (l != mlen) || (m != mmode);
    mlen  = l;
    mmode = m;
    lg    = (l > 4) ? 4 : l;
    L     = 1 << lg;
    x.v   = 1'b0;
    if (fl) begin
      samp.delete();
    end else if (v) begin
      samp.push_back(d);
      if (!m) begin
        if (samp.size() > L) void'(samp.pop_front());
        if (samp.size() == L) begin
          x.v   = 1'b1;
          m_out = mavg(lg);
        end
      end else if (samp.size() == L) begin
        x.v   = 1'b1;
        m_out = mavg(lg);
        samp.delete();
      end
    end
    x.d  = m_out;
    x.fd = !mmode && (samp.size() == L);
  endtask

  task automatic cyc(input bit e, input int l, input bit m, input bit v,
                     input logic [63:0] d);
    exp_t x;
    enable   = e;
    len_log2 = 3'(l);
    mode     = m;
    in_valid = v;
    in_data  = d;
    model(e, l, m, v, d, x);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("out_valid", 64'(out_valid), 64'(x.v));
    chk("out_data", out_data, x.d);
    chk("fill_done", 64'(fill_done), 64'(x.fd));
  endtask

  initial begin
    int cl;
    bit cm;
    bit ce;
    reset_n  = 1'b0;
    enable   = 1'b0;
    len_log2 = '0;
    mode     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_fill_done", 64'(fill_done), 64'd0);
    reset_n = 1'b1;

    // 1: sliding len=2 ramp
    cyc(1, 2, 0, 0, '0);
    for (int i = 0; i < 6; i++)
      cyc(1, 2, 0, 1, 64'(4 * i));

    // 2: block len=2, 1..8
    cyc(1, 2, 1, 0, '0);
    for (int i = 1; i <= 8; i++)
      cyc(1, 2, 1, 1, 64'(i));

    // 3: block len=1 negatives on ch1
    cyc(1, 1, 1, 0, '0);
    cyc(1, 1, 1, 1, {32'h0, 16'hFFFF, 16'h0});
    cyc(1, 1, 1, 1, {32'h0, 16'hFFFE, 16'h0});

    // full scale at len=4
    cyc(1, 4, 1, 0, '0);
    for (int i = 0; i < 16; i++)
      cyc(1, 4, 1, 1, {4{16'h8000}});
    for (int i = 0; i < 16; i++)
      cyc(1, 4, 1, 1, {4{16'h7FFF}});
    for (int i = 0; i < 16; i++)
      cyc(1, 4, 0, 1, {16'h0001, 16'h0000, 16'h7FFF, 16'h8000});
    for (int i = 0; i < 4; i++)
      cyc(1, 4, 0, 1, {16'h0001, 16'h0000, 16'h7FFF, 16'h8000});

    // 4: sliding len=3, then change to len=1 with a valid sample
    cyc(1, 3, 0, 0, '0);
    for (int i = 0; i < 10; i++)
      cyc(1, 3, 0, 1, {16'(i * 3), 16'(-i), 16'(i * 100), 16'(i * 7 + 1)});
    cyc(1, 1, 0, 1, {4{16'h1234}});
    cyc(1, 1, 0, 1, {16'd10, 16'd20, 16'hFFF0, 16'd5});
    cyc(1, 1, 0, 1, {16'd30, 16'd21, 16'hFFE0, 16'd8});
    cyc(1, 1, 0, 1, {16'd50, 16'd22, 16'hFFD0, 16'd9});

    // enable low: flush every cycle, out_data holds
    cyc(0, 1, 0, 1, {4{16'h5555}});
    cyc(0, 1, 0, 1, {4{16'h6666}});
    cyc(1, 1, 0, 1, {4{16'h0002}});
    cyc(1, 1, 0, 1, {4{16'h0004}});

    // 5: async reset mid-block
    cyc(1, 2, 1, 0, '0);
    cyc(1, 2, 1, 1, {4{16'h0100}});
    cyc(1, 2, 1, 1, {4{16'h0200}});
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", out_data, 64'd0);
    chk("mid_rst_fill_done", 64'(fill_done), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1, 2, 1, 0, '0);
    for (int i = 0; i < 5; i++)
      cyc(1, 2, 1, 1, {4{16'(i * 16 + 3)}});

    // 6: pass-through, gapped, both modes, then clamp
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 6; i++)
      cyc(1, 0, 0, i % 2 == 0, {16'(4000 + i), 16'(3000 + i), 16'(-2000 - i), 16'(1000 + i)});
    cyc(1, 0, 1, 0, '0);
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 1, i != 2, {16'(400 + i), 16'(300 + i), 16'(200 + i), 16'(100 + i)});
    cyc(1, 7, 0, 0, '0);
    for (int i = 0; i < 18; i++)
      cyc(1, 7, 0, 1, {16'(i), 16'(-i * 5), 16'(i * 11), 16'h7FFF});

    // random soak with occasional config changes
    cl = 2;
    cm = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ce = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 59) == 0) cl = $urandom_range(0, 6);
      if ($urandom_range(0, 79) == 0) cm = ~cm;
      cyc(ce, cl, cm, $urandom_range(0, 3) != 0, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
